path_deque: RTL
===============

Name: path_deque

Overview:
- Path memory for the maze solver: a stack/queue of 2-bit move directions.
- Solver pushes each accepted move and pops on dead-ends (backtrack); on pop it receives the undone direction as one-hot up/right/left/down.
- After solve, the replay phase drains entries oldest-first via qpop and streams moves downstream.
- err flags underflow, which the solver interprets as "no path" during backtrack and "replay finished" during move.

Parameters:
- DEPTH, 256, maximum stored moves (16x16 maze); power of two.
- AW, 8, pointer width, log2(DEPTH).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear (driven by solver START/FINISH)
- push  in  1  append din at top
- pop  in  1  remove top entry (backtrack)
- qpop  in  1  remove bottom entry (replay)
- din  in  2  direction: 00 up, 01 right, 10 left, 11 down
- up  out  1  last popped direction was up
- right  out  1  last popped direction was right
- left  out  1  last popped direction was left
- down  out  1  last popped direction was down
- move_dir  out  2  direction delivered by last qpop
- move_valid  out  1  one-cycle pulse: move_dir is new
- err  out  1  underflow flag
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Storage: circular buffer mem[DEPTH] x 2 bits.
  - head = oldest entry; tail = next free slot; count is AW+1 bits.
  - Pointers wrap modulo DEPTH.
- Reset (rst async) and clr (sync) act identically:
  - head = tail = count = 0.
  - up/right/left/down = 0, move_dir = 00, move_valid = 0, err = 0.
  - Memory contents are don't-care.
- Command priority per cycle: clr > pop > push > qpop.
  - Exception: pop+push together = replace (see below).
  - A command that loses priority is ignored.
- push (not full):
  - mem[tail] <= din; tail++; count++.
- push when full:
  - Write dropped; pointers unchanged; err unchanged.
  - full stays 1.
- pop (count > 0):
  - tail--; count--.
  - One-hot {up,right,left,down} <= decode(mem[tail-1]), valid next cycle (1-cycle latency), held until the next pop/clr.
  - err <= 0.
- pop when empty:
  - err <= 1; one-hot outputs all 0; pointers unchanged.
- pop+push same cycle (count > 0):
  - One-hot = old top; mem[tail-1] <= din.
  - count and pointers unchanged.
- pop+push same cycle when empty: treated as pop on empty.
- qpop (count > 0, no pop/push):
  - move_dir <= mem[head]; head++; count--.
  - move_valid = 1 for exactly one cycle; err <= 0.
- qpop when empty:
  - err <= 1; move_valid = 0; move_dir holds.
- err:
  - Registered; stays 1 until the next successful pop/qpop, push, or clr/rst.
  - A successful push also clears err.
- full, empty: combinational from count.
- Reset mid-operation: all state returns to reset values immediately (async); no partial writes persist as valid entries.

Optional Feature:
- Macro PATH_STAT_EN.
- When defined, adds outputs:
  - path_len [AW:0] = count.
  - peak_len [AW:0] = maximum count since last rst/clr.
    - Updated in the same cycle as count (registered).
    - Replace does not change it.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- rst; push 00, 01, 01, 11; qpop x4 -> move_dir 00, 01, 01, 11 with a move_valid pulse each; 5th qpop -> err=1, move_valid=0.
- Push 00, 10; pop -> next cycle left=1, others 0, count=1; pop -> up=1, empty=1; pop -> err=1, one-hot all 0.
- Push 01; pop+push din=11 same cycle -> right=1, count=1; then qpop -> move_dir=11.
- DEPTH=4: push x5 (00, 01, 10, 11, 00) -> full=1 after the 4th push, 5th dropped; qpop x4 -> 00, 01, 10, 11. Then push/qpop 6 times to verify pointer wrap order.
- Push 3 entries, assert rst asynchronously mid-cycle -> empty=1, err=0, outputs zero before the next edge; clr with pending qpop -> clr wins, no move_valid.
- PATH_STAT_EN: push x3, pop x2, push x1 -> path_len=2, peak_len=3; clr -> both 0.

Source files
------------

// File: rtl/path_deque_if.sv
// ============================================================================
// Module   : path_deque_if
// Purpose  : Solver <-> path memory bus: commands in, popped/replayed moves out.
//            Optional PATH_STAT_EN adds path_len / peak_len.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface path_deque_if #(
  parameter int AW = 8
);
  logic       clr;
  logic       push;
  logic       pop;
  logic       qpop;
  logic [1:0] din;
  logic       up;
  logic       right;
  logic       left;
  logic       down;
  logic [1:0] move_dir;
  logic       move_valid;
  logic       err;
  logic       full;
  logic       empty;
`ifdef PATH_STAT_EN
  logic [AW:0] path_len;
  logic [AW:0] peak_len;
`endif

  modport master (
    output clr, push, pop, qpop, din,
    input  up, right, left, down, move_dir, move_valid, err, full, empty
`ifdef PATH_STAT_EN
    , input path_len, peak_len
`endif
  );

  modport slave (
    input  clr, push, pop, qpop, din,
    output up, right, left, down, move_dir, move_valid, err, full, empty
`ifdef PATH_STAT_EN
    , output path_len, peak_len
`endif
  );
endinterface

`default_nettype wire

// File: rtl/path_deque.sv
// ============================================================================
// Module   : path_deque
// Purpose  : Circular stack/queue of 2-bit maze moves; LIFO backtrack, FIFO replay.
//            Optional macro PATH_STAT_EN adds path_len / peak_len outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module path_deque #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  path_deque_if.slave   bus
);
  localparam logic [AW:0] c_full_cnt = (AW+1)'(DEPTH);

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic [3:0]    r_oh;
  logic [1:0]    r_move_dir;
  logic          r_move_valid;
  logic          r_err;
`ifdef PATH_STAT_EN
  logic [AW:0]   r_peak;
`endif

  logic          w_empty;
  logic          w_full;
  logic          w_wr_en;
  logic [AW-1:0] w_top;
  logic [AW-1:0] w_wr_addr;
  logic [1:0]    w_top_dir;
  logic [1:0]    w_head_dir;
  logic [AW:0]   w_cnt_inc;

  // {up,right,left,down}
  function automatic logic [3:0] decode(input logic [1:0] d);
    logic [3:0] oh;
    case (d)
      2'b00:   oh = 4'b1000;
      2'b01:   oh = 4'b0100;
      2'b10:   oh = 4'b0010;
      default: oh = 4'b0001;
    endcase
    return oh;
  endfunction

  always_comb begin
    w_empty    = (r_count == '0);
    w_full     = (r_count == c_full_cnt);
    w_top      = r_tail - 1'b1;
    w_top_dir  = r_mem[w_top];
    w_head_dir = r_mem[r_head];
    w_cnt_inc  = r_count + 1'b1;
    w_wr_en    = 1'b0;
    w_wr_addr  = r_tail;
    // Replace (pop+push) overwrites the current top instead of appending.
    if (!rst && !bus.clr) begin
      if (bus.pop) begin
        if (bus.push && !w_empty) begin
          w_wr_en   = 1'b1;
          w_wr_addr = w_top;
        end
      end else if (bus.push && !w_full) begin
        w_wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_oh         <= '0;
      r_move_dir   <= 2'b00;
      r_move_valid <= 1'b0;
      r_err        <= 1'b0;
`ifdef PATH_STAT_EN
      r_peak       <= '0;
`endif
    end else if (bus.clr) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_oh         <= '0;
      r_move_dir   <= 2'b00;
      r_move_valid <= 1'b0;
      r_err        <= 1'b0;
`ifdef PATH_STAT_EN
      r_peak       <= '0;
`endif
    end else begin
      r_move_valid <= 1'b0;
      if (bus.pop) begin
        if (w_empty) begin
          r_err <= 1'b1;
          r_oh  <= '0;
        end else begin
          r_oh  <= decode(w_top_dir);
          r_err <= 1'b0;
          if (!bus.push) begin
            r_tail  <= w_top;
            r_count <= r_count - 1'b1;
          end
        end
      end else if (bus.push) begin
        // A push into a full deque is silently dropped, err untouched.
        if (!w_full) begin
          r_tail  <= r_tail + 1'b1;
          r_count <= w_cnt_inc;
          r_err   <= 1'b0;
`ifdef PATH_STAT_EN
          if (w_cnt_inc > r_peak) begin
            r_peak <= w_cnt_inc;
          end
`endif
        end
      end else if (bus.qpop) begin
        if (w_empty) begin
          r_err <= 1'b1;
        end else begin
          r_move_dir   <= w_head_dir;
          r_move_valid <= 1'b1;
          r_head       <= r_head + 1'b1;
          r_count      <= r_count - 1'b1;
          r_err        <= 1'b0;
        end
      end
    end
  end

  assign bus.up         = r_oh[3];
  assign bus.right      = r_oh[2];
  assign bus.left       = r_oh[1];
  assign bus.down       = r_oh[0];
  assign bus.move_dir   = r_move_dir;
  assign bus.move_valid = r_move_valid;
  assign bus.err        = r_err;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
`ifdef PATH_STAT_EN
  assign bus.path_len   = r_count;
  assign bus.peak_len   = r_peak;
`endif

endmodule

`default_nettype wire
